midi_tx_arb: RTL and testbench
==============================

# midi_tx_arb

Message-atomic arbiter that merges parsed MIDI traffic from up to NUM_SRC requesters (MIDI receivers, internal generators) onto one shared UART transmitter. Channel/system messages are granted round-robin and sent without interleaving other messages. Realtime bytes have priority and may be inserted between the bytes of a message in progress. Optional running-status compression drops repeated status bytes. The block sits between the router's per-input message sources and each output port's uart_tx.

## Interface
- NUM_SRC, 4: number of requesters (2..8).
- RUNNING_STATUS, 1: 1 = suppress a status byte equal to the last transmitted channel status.
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- msg_req  in  NUM_SRC  source i has a complete message; held until msg_ack[i].
- msg_data  in  24*NUM_SRC  source i at [24i+23:24i], ordered {status, data1, data2}.
- msg_len  in  2*NUM_SRC  source i byte count: 1..3, or 0 = discard.
- msg_ack  out  NUM_SRC  1-cycle pulse when source i's message is latched.
- rt_req  in  NUM_SRC  source i has a realtime byte (F8..FF); held until rt_ack[i].
- rt_data  in  8*NUM_SRC  realtime byte for source i.
- rt_ack  out  NUM_SRC  1-cycle pulse when rt_data[i] is issued to the transmitter.
- tx_data  out  8  byte to the transmitter; valid while tx_start = 1.
- tx_start  out  1  1-cycle strobe that starts one byte.
- tx_busy  in  1  high from the cycle after tx_start until the byte completes.
- grant  out  NUM_SRC  one-hot owner of the message in progress; 0 when no message is in progress.
- busy  out  1  a message is in progress.

## Operation
- State register: IDLE, GUARD, WAIT.
- Byte slot: a cycle in IDLE or WAIT with tx_busy = 0. Only a byte slot can issue a byte; the byte is issued in the following cycle.
- Realtime has priority in every slot. The lowest requesting index wins (fixed priority). The block pulses rt_ack and tx_start with tx_data = rt_data[i]. A realtime byte never changes last_status or the message byte pointer.
- Message grant: an IDLE slot with no rt_req and at least one msg_req grants a message.
  - Search starts at rr_ptr and proceeds upward with wrap.
  - The winner w gets msg_ack[w] and grant[w]. The 24-bit message and its length are latched, then rr_ptr = (w+1) mod NUM_SRC.
  - The first byte is issued in the same cycle as msg_ack.
- Running status skip: applies when RUNNING_STATUS = 1, status is 80..EF, status == last_status and len ≥ 2. The status byte is skipped and the first byte issued is data1.
- last_status update, applied when a message's status byte is issued or skipped:
  - 80..EF: last_status = status.
  - F0..F7: last_status = 0.
  - F8..FF: unchanged.
- len = 0: msg_ack pulses, nothing is transmitted, rr_ptr advances, state stays IDLE.
- Data bytes are sent verbatim. No validation of bit 7 is performed.
- After each tx_start the FSM enters GUARD for exactly 1 cycle. tx_busy is ignored in GUARD.
- Exit from GUARD: to WAIT if message bytes remain, otherwise to IDLE. grant and busy clear on entry to IDLE.
- Reset, at any time including mid-message: all outputs 0, state IDLE, rr_ptr = 0, last_status = 0. The latched message is abandoned with no re-send. Sources already acked are not re-acked.

## Timing
- All outputs are registered.
- Reset values: msg_ack = 0, rt_ack = 0, tx_start = 0, tx_data = 00, grant = 0, busy = 0.
- Grant latency: req high in IDLE slot cycle N → msg_ack, tx_start and first byte in cycle N+1.
- Byte spacing: tx_start in cycle T → GUARD in T+1 → next tx_start in C+1, where C is the first cycle ≥ T+2 with tx_busy = 0.
- With tx_busy tied 0, bytes are issued every 3 cycles. This holds within a message and across back-to-back messages.
- msg_ack and rt_ack are single-cycle pulses. The requester must deassert req by the cycle after the ack.
  - The block never re-samples the acked req earlier than 2 cycles after the ack.
- Simultaneous msg_req and rt_req in an IDLE slot: realtime goes first. The message is granted at the next slot.
- A realtime request arriving while message bytes remain takes the next slot. The remaining message bytes follow in order.
- tx_start and msg_ack/rt_ack are never asserted without each other for a byte that comes from a new request. Exception: the second and third bytes of a message get tx_start only.

## Test plan
- Single 3-byte message: source 0 sends {90,3C,64}, tx_busy tied 0.
  - Expect tx_start at N+1, N+4 and N+7 with bytes 90, 3C, 64.
  - Expect msg_ack[0] at N+1 and grant = 0001 from N+1 through N+8.
- Round-robin: sources 1 and 3 requesting continuously.
  - Expect grants 1, 3, 1, 3.
  - After reset, with sources 0 and 2 both requesting, source 0 wins first.
- Running status: {90,3C,64} then {90,3E,64} from different sources.
  - Expect 90 3C 64 3E 64.
  - Then {B0,07,7F} is sent in full.
  - An F2 message clears last_status, so a following 90 message is sent in full.
- Realtime insertion: rt_req[2] = F8 asserted while byte 3C of a 90 message is in flight.
  - Expect F8 then 64 on the wire.
  - Expect rt_ack[2] coincident with F8's tx_start and last_status still 90.
- Backpressure: tx_busy held high for 40 cycles after each start.
  - Expect no tx_start while tx_busy = 1.
  - Expect the next tx_start exactly 1 cycle after tx_busy falls.
- Async reset mid-message: rst low between byte 1 and byte 2.
  - Expect all outputs 0 immediately.
  - Expect no remaining bytes and normal grant from rr_ptr = 0 after release.
- len = 0: msg_ack pulses with no tx_start, and the next source is granted at the following slot.

Source files
------------

// File: rtl/midi_tx_arb.sv
// Merges per-source MIDI messages and realtime bytes onto one UART transmitter.
// Messages are sent atomically in round-robin order; realtime bytes may cut in between message bytes.
module midi_tx_arb #(
  parameter int NUM_SRC        = 4,
  parameter bit RUNNING_STATUS = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_SRC-1:0]     msg_req,
  input  logic [24*NUM_SRC-1:0]  msg_data,
  input  logic [2*NUM_SRC-1:0]   msg_len,
  output logic [NUM_SRC-1:0]     msg_ack,
  input  logic [NUM_SRC-1:0]     rt_req,
  input  logic [8*NUM_SRC-1:0]   rt_data,
  output logic [NUM_SRC-1:0]     rt_ack,
  output logic [7:0]             tx_data,
  output logic                   tx_start,
  input  logic                   tx_busy,
  output logic [NUM_SRC-1:0]     grant,
  output logic                   busy
);
  localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {IDLE, GUARD, WAIT} state_e;

  state_e             state_q, state_d;
  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [7:0]         last_status_q, last_status_d;
  logic [23:0]        buf_q, buf_d;
  logic [1:0]         rem_q, rem_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic               busy_q, busy_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic [NUM_SRC-1:0] msg_ack_q, msg_ack_d;
  logic [NUM_SRC-1:0] rt_ack_q, rt_ack_d;

  logic [23:0] words [NUM_SRC];
  logic [1:0]  lens  [NUM_SRC];
  logic [7:0]  rtb   [NUM_SRC];

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
    assign words[g] = msg_data[24*g +: 24];
    assign lens[g]  = msg_len[2*g +: 2];
    assign rtb[g]   = rt_data[8*g +: 8];
  end

  // An ack'd request may still be high in the cycle after its ack; mask it.
  logic [NUM_SRC-1:0] rt_m, msg_m;
  assign rt_m  = rt_req  & ~rt_ack_q;
  assign msg_m = msg_req & ~msg_ack_q;

  logic          rt_hit, msg_hit;
  logic [PW-1:0] rt_idx, msg_idx;
  logic [PW:0]   sum;

  always_comb begin
    rt_hit  = 1'b0;
    rt_idx  = '0;
    msg_hit = 1'b0;
    msg_idx = '0;
    sum     = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!rt_hit && rt_m[i]) begin
        rt_hit = 1'b1;
        rt_idx = PW'(i);
      end
    end
    for (int k = 0; k < NUM_SRC; k++) begin
      sum = {1'b0, rr_ptr_q} + (PW+1)'(k);
      if (sum >= (PW+1)'(NUM_SRC)) sum = sum - (PW+1)'(NUM_SRC);
      if (!msg_hit && msg_m[sum[PW-1:0]]) begin
        msg_hit = 1'b1;
        msg_idx = sum[PW-1:0];
      end
    end
  end

  logic [23:0] m_word;
  logic [1:0]  m_len;
  logic [7:0]  m_stat;
  logic        is_chan, is_sys, skip, slot;

  assign m_word  = words[msg_idx];
  assign m_len   = lens[msg_idx];
  assign m_stat  = m_word[23:16];
  assign is_chan = m_stat[7] && (m_stat[7:4] != 4'hF);
  assign is_sys  = (m_stat[7:4] == 4'hF) && !m_stat[3];
  assign skip    = RUNNING_STATUS && is_chan && (m_stat == last_status_q) && (m_len >= 2'd2);
  // The cycle that shows tx_start is never a slot, giving the 3-cycle byte cadence.
  assign slot    = ((state_q == IDLE) || (state_q == WAIT)) && !tx_busy && !tx_start_q;

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    last_status_d = last_status_q;
    buf_d         = buf_q;
    rem_d         = rem_q;
    grant_d       = grant_q;
    busy_d        = busy_q;
    tx_data_d     = tx_data_q;
    tx_start_d    = 1'b0;
    msg_ack_d     = '0;
    rt_ack_d      = '0;
    if (tx_start_q) begin
      state_d = GUARD;
    end else if (state_q == GUARD) begin
      if (rem_q != 2'd0) begin
        state_d = WAIT;
      end else begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    end else if (slot) begin
      if (rt_hit) begin
        rt_ack_d[rt_idx] = 1'b1;
        tx_start_d       = 1'b1;
        tx_data_d        = rtb[rt_idx];
      end else if (state_q == WAIT && rem_q != 2'd0) begin
        tx_start_d = 1'b1;
        tx_data_d  = buf_q[23:16];
        buf_d      = {buf_q[15:0], 8'h00};
        rem_d      = rem_q - 2'd1;
      end else if (state_q == IDLE && msg_hit) begin
        msg_ack_d[msg_idx] = 1'b1;
        rr_ptr_d = (msg_idx == PW'(NUM_SRC-1)) ? '0 : msg_idx + 1'b1;
        if (m_len != 2'd0) begin
          grant_d          = '0;
          grant_d[msg_idx] = 1'b1;
          busy_d           = 1'b1;
          tx_start_d       = 1'b1;
          if (is_chan)     last_status_d = m_stat;
          else if (is_sys) last_status_d = 8'h00;
          if (skip) begin
            tx_data_d = m_word[15:8];
            buf_d     = {m_word[7:0], 16'h0000};
            rem_d     = m_len - 2'd2;
          end else begin
            tx_data_d = m_stat;
            buf_d     = {m_word[15:0], 8'h00};
            rem_d     = m_len - 2'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      last_status_q <= 8'h00;
      buf_q         <= '0;
      rem_q         <= 2'd0;
      grant_q       <= '0;
      busy_q        <= 1'b0;
      tx_data_q     <= 8'h00;
      tx_start_q    <= 1'b0;
      msg_ack_q     <= '0;
      rt_ack_q      <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      last_status_q <= last_status_d;
      buf_q         <= buf_d;
      rem_q         <= rem_d;
      grant_q       <= grant_d;
      busy_q        <= busy_d;
      tx_data_q     <= tx_data_d;
      tx_start_q    <= tx_start_d;
      msg_ack_q     <= msg_ack_d;
      rt_ack_q      <= rt_ack_d;
    end
  end

  assign msg_ack  = msg_ack_q;
  assign rt_ack   = rt_ack_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign grant    = grant_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_midi_tx_arb.sv
// Directed bench for midi_tx_arb: per-cycle output log plus hand-computed expectations.
module tb_midi_tx_arb;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N-1:0]    msg_req  = '0;
  logic [24*N-1:0] msg_data = '0;
  logic [2*N-1:0]  msg_len  = '0;
  logic [N-1:0]    rt_req   = '0;
  logic [8*N-1:0]  rt_data  = '0;
  logic [N-1:0]    msg_ack, rt_ack, grant;
  logic [7:0]      tx_data;
  logic            tx_start, tx_busy, busy;

  logic bp_en = 1'b0;
  int   bcnt  = 0;

  midi_tx_arb #(.NUM_SRC(N), .RUNNING_STATUS(1'b1)) dut (
    .clk(clk), .rst(rst),
    .msg_req(msg_req), .msg_data(msg_data), .msg_len(msg_len), .msg_ack(msg_ack),
    .rt_req(rt_req), .rt_data(rt_data), .rt_ack(rt_ack),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  // Transmitter model: busy for 40 cycles starting the cycle after tx_start.
  always @(posedge clk) begin
    if (tx_start && bp_en) bcnt <= 40;
    else if (bcnt > 0)     bcnt <= bcnt - 1;
  end
  assign tx_busy = bp_en && (bcnt != 0);

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic       s_start [1024];
  logic [7:0] s_data  [1024];
  logic [N-1:0] s_mack [1024];
  logic [N-1:0] s_rack [1024];
  logic [N-1:0] s_gnt  [1024];
  logic       s_busy  [1024];
  logic       s_txb   [1024];
  logic [7:0] txq [$];
  int         ackq [$];
  logic [25:0] pend [N][$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [25:0] e;
    @(negedge clk);
    cyc++;
    if (cyc < 1024) begin
      s_start[cyc] = tx_start;
      s_data[cyc]  = tx_data;
      s_mack[cyc]  = msg_ack;
      s_rack[cyc]  = rt_ack;
      s_gnt[cyc]   = grant;
      s_busy[cyc]  = busy;
      s_txb[cyc]   = tx_busy;
    end
    if (tx_start) txq.push_back(tx_data);
    for (int i = 0; i < N; i++) begin
      if (msg_ack[i]) begin
        ackq.push_back(i);
        if (pend[i].size() > 0) begin
          e = pend[i].pop_front();
          msg_len[2*i +: 2]   = e[25:24];
          msg_data[24*i +: 24] = e[23:0];
        end else begin
          msg_req[i] = 1'b0;
        end
      end
      if (rt_ack[i]) rt_req[i] = 1'b0;
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic post(input int i, input logic [1:0] len, input logic [23:0] d);
    if (msg_req[i]) pend[i].push_back({len, d});
    else begin
      msg_len[2*i +: 2]    = len;
      msg_data[24*i +: 24] = d;
      msg_req[i]           = 1'b1;
    end
  endtask

  function automatic int cnt_start(input int a, input int b);
    int c = 0;
    for (int k = a; k <= b; k++) if (s_start[k]) c++;
    return c;
  endfunction

  function automatic int cnt_bp(input int a, input int b);
    int c = 0;
    for (int k = a; k <= b; k++) if (s_start[k] && s_txb[k]) c++;
    return c;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_msg_ack"}, msg_ack, 0);
    chk({tag, "_rt_ack"}, rt_ack, 0);
    chk({tag, "_tx_start"}, tx_start, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  logic [7:0] exp_rs [11];
  int c0, c1, c2;

  initial begin
    exp_rs = '{8'h3E, 8'h64, 8'hB0, 8'h07, 8'h7F, 8'hF2, 8'h01, 8'h02, 8'h90, 8'h3C, 8'h64};

    // Reset state
    run(3);
    chk_zero("reset");
    rst = 1'b1;
    run(2);

    // Single 3-byte message from source 0
    post(0, 2'd3, 24'h903C64);
    c0 = cyc;
    run(12);
    chk("s1_start1", s_start[c0+1], 1);
    chk("s1_byte1", s_data[c0+1], 8'h90);
    chk("s1_ack", s_mack[c0+1], 4'b0001);
    chk("s1_byte2", {s_start[c0+4], s_data[c0+4]}, {1'b1, 8'h3C});
    chk("s1_byte3", {s_start[c0+7], s_data[c0+7]}, {1'b1, 8'h64});
    chk("s1_nstart", cnt_start(c0, c0+12), 3);
    chk("s1_gnt_first", s_gnt[c0+1], 4'b0001);
    chk("s1_gnt_last", s_gnt[c0+8], 4'b0001);
    chk("s1_gnt_clear", s_gnt[c0+9], 4'b0000);
    chk("s1_busy_clear", s_busy[c0+9], 0);

    // Running status: repeated 90 skipped, B0 and F2 sent whole, F2 clears last status
    txq.delete();
    post(2, 2'd3, 24'h903E64); run(12);
    post(3, 2'd3, 24'hB0077F); run(12);
    post(0, 2'd3, 24'hF20102); run(12);
    post(1, 2'd3, 24'h903C64); run(12);
    chk("rs_count", txq.size(), 11);
    for (int k = 0; k < 11; k++)
      chk($sformatf("rs_byte%0d", k), (k < txq.size()) ? txq[k] : 8'hxx, exp_rs[k]);

    // Realtime insertion while 3C is in flight
    post(0, 2'd2, 24'hC00500); run(10);
    post(1, 2'd3, 24'h903C64);
    c0 = cyc;
    run(4);
    rt_data[8*2 +: 8] = 8'hF8;
    rt_req[2] = 1'b1;
    run(10);
    chk("rt_byte2", s_data[c0+4], 8'h3C);
    chk("rt_f8", {s_start[c0+7], s_data[c0+7]}, {1'b1, 8'hF8});
    chk("rt_ack", s_rack[c0+7], 4'b0100);
    chk("rt_no_mack", s_mack[c0+7], 4'b0000);
    chk("rt_gnt_hold", s_gnt[c0+7], 4'b0010);
    chk("rt_resume", {s_start[c0+10], s_data[c0+10]}, {1'b1, 8'h64});
    txq.delete();
    post(3, 2'd3, 24'h903E64); run(12);
    chk("rt_last_cnt", txq.size(), 2);
    chk("rt_last_b0", (txq.size() > 0) ? txq[0] : 8'hxx, 8'h3E);

    // Simultaneous realtime and message request in IDLE
    rt_data[8*1 +: 8] = 8'hFA;
    rt_req[1] = 1'b1;
    post(0, 2'd1, 24'hF60000);
    c0 = cyc;
    run(8);
    chk("sim_rt_first", {s_start[c0+1], s_data[c0+1]}, {1'b1, 8'hFA});
    chk("sim_rt_ack", s_rack[c0+1], 4'b0010);
    chk("sim_no_mack", s_mack[c0+1], 4'b0000);
    chk("sim_msg_ack", s_mack[c0+4], 4'b0001);
    chk("sim_msg_byte", {s_start[c0+4], s_data[c0+4]}, {1'b1, 8'hF6});

    // Round-robin between sources 1 and 3
    ackq.delete();
    post(1, 2'd1, 24'hC10000); post(1, 2'd1, 24'hD10000);
    post(3, 2'd1, 24'hC30000); post(3, 2'd1, 24'hD30000);
    run(20);
    chk("rr_count", ackq.size(), 4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("rr_grant%0d", k), (k < ackq.size()) ? ackq[k] : -1, (k % 2 == 0) ? 1 : 3);

    // Async reset between byte 1 and byte 2
    post(1, 2'd3, 24'h903C64);
    c0 = cyc;
    run(2);
    chk("ar_pre_byte", s_data[c0+1], 8'h90);
    chk("ar_pre_gnt", grant, 4'b0010);
    #1 rst = 1'b0;
    #1 chk_zero("ar_async");
    run(3);
    rst = 1'b1;
    c1 = cyc;
    run(6);
    chk("ar_no_resend", cnt_start(c1, c1+6), 0);
    post(0, 2'd3, 24'h903C64);
    post(2, 2'd1, 24'hF60000);
    c2 = cyc;
    run(14);
    chk("ar_rr0_ack", s_mack[c2+1], 4'b0001);
    chk("ar_full_status", s_data[c2+1], 8'h90);
    chk("ar_gnt", s_gnt[c2+1], 4'b0001);
    chk("ar_next_ack", s_mack[c2+10], 4'b0100);

    // Backpressure: 40-cycle busy after every start
    bp_en = 1'b1;
    post(3, 2'd3, 24'hB0077F);
    c0 = cyc;
    run(90);
    bp_en = 1'b0;
    chk("bp_b1", {s_start[c0+1], s_data[c0+1]}, {1'b1, 8'hB0});
    chk("bp_busy_seen", s_txb[c0+2], 1);
    chk("bp_wait", {s_start[c0+42], s_txb[c0+42]}, {1'b0, 1'b0});
    chk("bp_b2", {s_start[c0+43], s_data[c0+43]}, {1'b1, 8'h07});
    chk("bp_b3", {s_start[c0+85], s_data[c0+85]}, {1'b1, 8'h7F});
    chk("bp_nstart", cnt_start(c0, c0+90), 3);
    chk("bp_overlap", cnt_bp(c0, c0+90), 0);
    run(4);

    // len = 0 discard, next source granted at the following slot
    post(0, 2'd0, 24'h000000);
    post(1, 2'd1, 24'hF60000);
    c0 = cyc;
    run(8);
    chk("l0_ack", s_mack[c0+1], 4'b0001);
    chk("l0_no_start", s_start[c0+1], 0);
    chk("l0_no_gnt", s_gnt[c0+1], 4'b0000);
    chk("l0_next_ack", s_mack[c0+2], 4'b0010);
    chk("l0_next_byte", {s_start[c0+2], s_data[c0+2]}, {1'b1, 8'hF6});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
